// File: rtl/tf530_pkg.sv
// Shared types and constants for the TF530 IDE PIO sequencer.
package tf530_pkg;

  // state | meaning
  // IDLE    | waiting for a decoded IDE cycle, all outputs inactive
  // SETUP   | CS/DA driven, counting address setup before the strobe
  // STROBE  | IOR/IOW low, counting pulse width then waiting on IORDY
  // TERM    | strobe released, DSACK or BERR held until AS20 negates
  // RECOVER | CS released, counting recovery before a new cycle
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    TERM    = 3'd3,
    RECOVER = 3'd4
  } ide_state_t;

  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_NONE = 2'b11;
  localparam logic [1:0] CS_NONE    = 2'b11;

  // Low-active {CS1n, CS0n}: A12 picks the control block (CS1) over the command block (CS0).
  function automatic logic [1:0] cs_select(input logic a12);
    return a12 ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/tf530_ide_ctrl.sv
// ATA PIO cycle sequencer: turns a decoded 68030 IDE access into CS/DA,
// IOR/IOW strobes with setup/pulse/recovery timing, IORDY stretching,
// 16-bit DSACK termination and a watchdog bus error.
module tf530_ide_ctrl
  import tf530_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 8,
  parameter int RECOVER_CYC  = 3,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       IDE_ACCESS,
  input  logic       AS20,
  input  logic       RW20,
  input  logic [4:2] AB,
  input  logic       A12,
  input  logic       IDEWAIT,
  output logic [1:0] IDE_CS,
  output logic [2:0] IDE_DA,
  output logic       IDE_IORn,
  output logic       IDE_IOWn,
  output logic       IDE_BUFOEn,
  output logic       IDE_DIR,
  output logic       RD_LATCH,
  output logic [1:0] DSACKn,
  output logic       BERRn
);

  localparam logic [4:0] SETUP_LOAD   = 5'(SETUP_CYC - 1);
  localparam logic [4:0] STROBE_LOAD  = 5'(STROBE_CYC - 1);
  localparam logic [4:0] RECOVER_LOAD = 5'(RECOVER_CYC);
  localparam logic [7:0] WDOG_LIMIT   = 8'(WAIT_TIMEOUT);

  ide_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [7:0] wdog, wdog_nxt, wdog_inc;

  logic [1:0] cs_reg, cs_nxt;
  logic [2:0] da_reg, da_nxt;
  logic       ior_reg, ior_nxt;
  logic       iow_reg, iow_nxt;
  logic       bufoe_reg, bufoe_nxt;
  logic       dir_reg, dir_nxt;
  logic       rd_latch_reg, rd_latch_nxt;
  logic [1:0] dsack_reg, dsack_nxt;
  logic       berr_reg, berr_nxt;

  // Saturating watchdog increment so a long IORDY stall can never wrap.
  assign wdog_inc = (wdog == 8'hFF) ? wdog : wdog + 8'd1;

  // State, counters and every output are registered; nothing is combinational from inputs.
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      wdog         <= '0;
      cs_reg       <= CS_NONE;
      da_reg       <= '0;
      ior_reg      <= 1'b1;
      iow_reg      <= 1'b1;
      bufoe_reg    <= 1'b1;
      dir_reg      <= 1'b0;
      rd_latch_reg <= 1'b0;
      dsack_reg    <= DSACK_NONE;
      berr_reg     <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      wdog         <= wdog_nxt;
      cs_reg       <= cs_nxt;
      da_reg       <= da_nxt;
      ior_reg      <= ior_nxt;
      iow_reg      <= iow_nxt;
      bufoe_reg    <= bufoe_nxt;
      dir_reg      <= dir_nxt;
      rd_latch_reg <= rd_latch_nxt;
      dsack_reg    <= dsack_nxt;
      berr_reg     <= berr_nxt;
    end
  end

  // Next-state and next-output decode; an AS20 negation before TERM aborts without DSACK.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wdog_nxt     = wdog;
    cs_nxt       = cs_reg;
    da_nxt       = da_reg;
    ior_nxt      = ior_reg;
    iow_nxt      = iow_reg;
    bufoe_nxt    = bufoe_reg;
    dir_nxt      = dir_reg;
    rd_latch_nxt = 1'b0;
    dsack_nxt    = dsack_reg;
    berr_nxt     = berr_reg;

    case (state)
      IDLE: begin
        if (!IDE_ACCESS) begin
          cs_nxt    = cs_select(A12);
          da_nxt    = AB;
          dir_nxt   = RW20;
          bufoe_nxt = 1'b0;
          cnt_nxt   = SETUP_LOAD;
          state_nxt = SETUP;
        end
      end

      SETUP, STROBE: begin
        if (AS20) begin
          ior_nxt   = 1'b1;
          iow_nxt   = 1'b1;
          cs_nxt    = CS_NONE;
          da_nxt    = '0;
          dir_nxt   = 1'b0;
          bufoe_nxt = 1'b1;
          cnt_nxt   = RECOVER_LOAD;
          state_nxt = RECOVER;
        end else if (state == SETUP) begin
          if (cnt == '0) begin
            ior_nxt   = ~dir_reg;
            iow_nxt   = dir_reg;
            cnt_nxt   = STROBE_LOAD;
            wdog_nxt  = '0;
            state_nxt = STROBE;
          end else begin
            cnt_nxt = cnt - 5'd1;
          end
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 5'd1;
        end else if (IDEWAIT) begin
          ior_nxt      = 1'b1;
          iow_nxt      = 1'b1;
          rd_latch_nxt = dir_reg;
          dsack_nxt    = DSACK_16;
          state_nxt    = TERM;
        end else begin
          // Comparing the incremented value makes BERR land exactly WAIT_TIMEOUT
          // cycles after the pulse counter expired.
          wdog_nxt = wdog_inc;
          if (wdog_inc == WDOG_LIMIT) begin
            ior_nxt   = 1'b1;
            iow_nxt   = 1'b1;
            berr_nxt  = 1'b0;
            state_nxt = TERM;
          end
        end
      end

      TERM: begin
        if (AS20) begin
          dsack_nxt = DSACK_NONE;
          berr_nxt  = 1'b1;
          cs_nxt    = CS_NONE;
          da_nxt    = '0;
          dir_nxt   = 1'b0;
          bufoe_nxt = 1'b1;
          cnt_nxt   = RECOVER_LOAD;
          state_nxt = RECOVER;
        end
      end

      RECOVER: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign IDE_CS     = cs_reg;
  assign IDE_DA     = da_reg;
  assign IDE_IORn   = ior_reg;
  assign IDE_IOWn   = iow_reg;
  assign IDE_BUFOEn = bufoe_reg;
  assign IDE_DIR    = dir_reg;
  assign RD_LATCH   = rd_latch_reg;
  assign DSACKn     = dsack_reg;
  assign BERRn      = berr_reg;

endmodule

// File: tb/tb_tf530_ide_ctrl.sv
// Directed bench for tf530_ide_ctrl with default timing parameters
// (setup 2, strobe 8, recover 3, timeout 255).
module tb_tf530_ide_ctrl;

  logic       CLKCPU;
  logic       RESET;
  logic       IDE_ACCESS;
  logic       AS20;
  logic       RW20;
  logic [4:2] AB;
  logic       A12;
  logic       IDEWAIT;
  logic [1:0] IDE_CS;
  logic [2:0] IDE_DA;
  logic       IDE_IORn;
  logic       IDE_IOWn;
  logic       IDE_BUFOEn;
  logic       IDE_DIR;
  logic       RD_LATCH;
  logic [1:0] DSACKn;
  logic       BERRn;

  int total = 0;
  int bad   = 0;

  tf530_ide_ctrl dut (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .IDE_ACCESS(IDE_ACCESS),
    .AS20      (AS20),
    .RW20      (RW20),
    .AB        (AB),
    .A12       (A12),
    .IDEWAIT   (IDEWAIT),
    .IDE_CS    (IDE_CS),
    .IDE_DA    (IDE_DA),
    .IDE_IORn  (IDE_IORn),
    .IDE_IOWn  (IDE_IOWn),
    .IDE_BUFOEn(IDE_BUFOEn),
    .IDE_DIR   (IDE_DIR),
    .RD_LATCH  (RD_LATCH),
    .DSACKn    (DSACKn),
    .BERRn     (BERRn)
  );

  initial CLKCPU = 1'b0;
  always #5 CLKCPU = ~CLKCPU;

  // One rising edge, then step off it so samples and drives are away from the edge.
  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic start_access(input logic rw, input logic [2:0] ab, input logic a12);
    RW20       = rw;
    AB         = ab;
    A12        = a12;
    AS20       = 1'b0;
    IDE_ACCESS = 1'b0;
  endtask

  task automatic end_access();
    AS20       = 1'b1;
    IDE_ACCESS = 1'b1;
  endtask

  // Let the sequencer drain back to IDLE.
  task automatic settle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  // Ticks until a strobe is low; edges counts edges taken (0 on timeout).
  task automatic wait_strobe(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((IDE_IORn & IDE_IOWn) == 1'b0) begin
        edges = i;
        break;
      end
    end
  endtask

  // Called just after the asserting edge; counts edges with the strobe low.
  task automatic measure_width(output int width);
    width = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((IDE_IORn & IDE_IOWn) == 1'b0) width++;
      else break;
    end
  endtask

  task automatic test_reset();
    int e;
    total++;
    if ({IDE_CS, IDE_DA, IDE_IORn, IDE_IOWn, IDE_BUFOEn, IDE_DIR, RD_LATCH, DSACKn, BERRn}
        !== {2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: got cs=%b da=%0d ior=%b iow=%b oe=%b dir=%b rdl=%b dsack=%b berr=%b",
               IDE_CS, IDE_DA, IDE_IORn, IDE_IOWn, IDE_BUFOEn, IDE_DIR, RD_LATCH, DSACKn, BERRn);
    end
    start_access(1'b1, 3'd5, 1'b0);
    wait_strobe(e);
    tick();
    tick();
    total++;
    if (IDE_IORn !== 1'b0) begin
      bad++;
      $display("FAIL reset_pre_strobe: ior=%b expected 0", IDE_IORn);
    end
    RESET = 1'b1;
    tick();
    total++;
    if ({IDE_CS, IDE_DA, IDE_IORn, IDE_IOWn, IDE_BUFOEn, IDE_DIR, RD_LATCH, DSACKn, BERRn}
        !== {2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_strobe: got cs=%b da=%0d ior=%b iow=%b oe=%b dir=%b dsack=%b berr=%b expected reset values",
               IDE_CS, IDE_DA, IDE_IORn, IDE_IOWn, IDE_BUFOEn, IDE_DIR, DSACKn, BERRn);
    end
    RESET = 1'b0;
    end_access();
    tick();
    tick();
    total++;
    if ({IDE_CS, IDE_IORn, IDE_BUFOEn} !== {2'b11, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_idle_after: cs=%b ior=%b oe=%b expected 11 1 1", IDE_CS, IDE_IORn, IDE_BUFOEn);
    end
    settle();
  endtask

  task automatic test_read();
    int e, w;
    start_access(1'b1, 3'b111, 1'b0);
    tick();
    total++;
    if ({IDE_CS, IDE_DA, IDE_BUFOEn, IDE_DIR, IDE_IORn} !== {2'b10, 3'd7, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL read_setup: cs=%b da=%0d oe=%b dir=%b ior=%b expected 10 7 0 1 1",
               IDE_CS, IDE_DA, IDE_BUFOEn, IDE_DIR, IDE_IORn);
    end
    wait_strobe(e);
    total++;
    if (e !== 2 || IDE_IORn !== 1'b0 || IDE_IOWn !== 1'b1) begin
      bad++;
      $display("FAIL read_strobe_edge: strobe on edge %0d (ior=%b iow=%b) expected edge 3 of access", e + 1, IDE_IORn, IDE_IOWn);
    end
    measure_width(w);
    total++;
    if (w !== 8) begin
      bad++;
      $display("FAIL read_width: got %0d expected 8", w);
    end
    total++;
    if (RD_LATCH !== 1'b1 || DSACKn !== 2'b01 || IDE_CS !== 2'b10) begin
      bad++;
      $display("FAIL read_release: rdl=%b dsack=%b cs=%b expected 1 01 10", RD_LATCH, DSACKn, IDE_CS);
    end
    tick();
    total++;
    if (RD_LATCH !== 1'b0 || DSACKn !== 2'b01 || IDE_CS !== 2'b10 || IDE_BUFOEn !== 1'b0) begin
      bad++;
      $display("FAIL read_term_hold: rdl=%b dsack=%b cs=%b oe=%b expected 0 01 10 0", RD_LATCH, DSACKn, IDE_CS, IDE_BUFOEn);
    end
    end_access();
    tick();
    total++;
    if (DSACKn !== 2'b11 || IDE_CS !== 2'b11 || IDE_BUFOEn !== 1'b1) begin
      bad++;
      $display("FAIL read_term_exit: dsack=%b cs=%b oe=%b expected 11 11 1", DSACKn, IDE_CS, IDE_BUFOEn);
    end
    settle();
  endtask

  task automatic test_write();
    int e, w;
    logic dir_bad;
    start_access(1'b0, 3'b110, 1'b1);
    wait_strobe(e);
    total++;
    if ({IDE_CS, IDE_DA, IDE_IOWn, IDE_IORn, IDE_DIR} !== {2'b01, 3'd6, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL write_strobe: cs=%b da=%0d iow=%b ior=%b dir=%b expected 01 6 0 1 0",
               IDE_CS, IDE_DA, IDE_IOWn, IDE_IORn, IDE_DIR);
    end
    dir_bad = 1'b0;
    w = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (IDE_DIR !== 1'b0 || IDE_CS !== 2'b01) dir_bad = 1'b1;
      if (IDE_IOWn == 1'b0) w++;
      else break;
    end
    total++;
    if (w !== 8) begin
      bad++;
      $display("FAIL write_width: got %0d expected 8", w);
    end
    total++;
    if (dir_bad !== 1'b0 || DSACKn !== 2'b01 || RD_LATCH !== 1'b0) begin
      bad++;
      $display("FAIL write_release: dir_changed=%b dsack=%b rdl=%b expected 0 01 0", dir_bad, DSACKn, RD_LATCH);
    end
    end_access();
    settle();
  endtask

  task automatic test_iordy_stretch();
    int e;
    start_access(1'b1, 3'd2, 1'b0);
    wait_strobe(e);
    for (int i = 0; i < 5; i++) tick();
    IDEWAIT = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (IDE_IORn !== 1'b0 || DSACKn !== 2'b11) begin
      bad++;
      $display("FAIL stretch_hold: at strobe edge 13 ior=%b dsack=%b expected 0 11", IDE_IORn, DSACKn);
    end
    IDEWAIT = 1'b1;
    tick();
    total++;
    if (IDE_IORn !== 1'b1 || DSACKn !== 2'b01 || RD_LATCH !== 1'b1) begin
      bad++;
      $display("FAIL stretch_release: ior=%b dsack=%b rdl=%b expected 1 01 1 after 13 low edges", IDE_IORn, DSACKn, RD_LATCH);
    end
    end_access();
    tick();
    total++;
    if (DSACKn !== 2'b11 || BERRn !== 1'b1) begin
      bad++;
      $display("FAIL stretch_single_dsack: dsack=%b berr=%b expected 11 1", DSACKn, BERRn);
    end
    settle();
  endtask

  task automatic test_timeout();
    int e;
    IDEWAIT = 1'b0;
    start_access(1'b1, 3'd1, 1'b0);
    wait_strobe(e);
    // cnt reaches 0 seven edges after the strobe asserts; BERR 255 edges after that.
    for (int i = 0; i < 261; i++) tick();
    total++;
    if (BERRn !== 1'b1 || IDE_IORn !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: one edge before limit berr=%b ior=%b expected 1 0", BERRn, IDE_IORn);
    end
    tick();
    total++;
    if (BERRn !== 1'b0 || IDE_IORn !== 1'b1 || DSACKn !== 2'b11 || RD_LATCH !== 1'b0) begin
      bad++;
      $display("FAIL timeout_berr: berr=%b ior=%b dsack=%b rdl=%b expected 0 1 11 0", BERRn, IDE_IORn, DSACKn, RD_LATCH);
    end
    tick();
    total++;
    if (BERRn !== 1'b0 || IDE_CS !== 2'b10) begin
      bad++;
      $display("FAIL timeout_hold: berr=%b cs=%b expected 0 10 until AS20 rises", BERRn, IDE_CS);
    end
    IDEWAIT = 1'b1;
    end_access();
    tick();
    total++;
    if (BERRn !== 1'b1 || IDE_CS !== 2'b11 || DSACKn !== 2'b11) begin
      bad++;
      $display("FAIL timeout_exit: berr=%b cs=%b dsack=%b expected 1 11 11", BERRn, IDE_CS, DSACKn);
    end
    settle();
  endtask

  task automatic test_abort();
    logic leaked;
    start_access(1'b1, 3'd4, 1'b0);
    tick();
    end_access();
    tick();
    total++;
    if (IDE_CS !== 2'b11 || IDE_IORn !== 1'b1) begin
      bad++;
      $display("FAIL abort_release: cs=%b ior=%b expected 11 1", IDE_CS, IDE_IORn);
    end
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (IDE_IORn !== 1'b1 || IDE_IOWn !== 1'b1 || DSACKn !== 2'b11) leaked = 1'b1;
    end
    total++;
    if (leaked !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_strobe: strobe or dsack seen=%b expected 0", leaked);
    end
  endtask

  task automatic test_back_to_back();
    int e, w, gap;
    start_access(1'b0, 3'd0, 1'b0);
    wait_strobe(e);
    measure_width(w);
    total++;
    if (w !== 8 || DSACKn !== 2'b01) begin
      bad++;
      $display("FAIL b2b_first: width=%0d dsack=%b expected 8 01", w, DSACKn);
    end
    end_access();
    tick();
    start_access(1'b1, 3'd3, 1'b1);
    wait_strobe(e);
    gap = e + 1;
    total++;
    if (gap !== 8 || IDE_IORn !== 1'b0 || IDE_CS !== 2'b01 || IDE_DA !== 3'd3) begin
      bad++;
      $display("FAIL b2b_gap: gap=%0d ior=%b cs=%b da=%0d expected 8 0 01 3", gap, IDE_IORn, IDE_CS, IDE_DA);
    end
    measure_width(w);
    total++;
    if (w !== 8 || DSACKn !== 2'b01 || RD_LATCH !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: width=%0d dsack=%b rdl=%b expected 8 01 1", w, DSACKn, RD_LATCH);
    end
    end_access();
    settle();
  endtask

  initial begin
    RESET      = 1'b1;
    IDE_ACCESS = 1'b1;
    AS20       = 1'b1;
    RW20       = 1'b1;
    AB         = 3'd0;
    A12        = 1'b0;
    IDEWAIT    = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    test_reset();
    test_read();
    test_write();
    test_iordy_stretch();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tf530_ide_ctrl.md
# tf530_ide_ctrl

PIO cycle sequencer for the on-board IDE port, directly downstream of the IDE address decode (`IDE_ACCESS`, low-active for $DA0000–$DA7FFF). It converts a qualified 68030 bus cycle into ATA PIO signalling:

- chip select and register address
- IOR/IOW strobes with programmable setup, pulse and recovery
- IORDY (`IDEWAIT`) stretching
- 16-bit DSACK termination back to the CPU

A watchdog converts a stuck IORDY into a bus error.

## Interface
Parameters:
- `SETUP_CYC`, 2: CLKCPU cycles from CS/DA valid to strobe assertion (1–15).
- `STROBE_CYC`, 8: minimum strobe-low cycles (1–31).
- `RECOVER_CYC`, 3: cycles after strobe release before a new cycle may start (0–15).
- `WAIT_TIMEOUT`, 255: max cycles strobe may be held by IORDY low before BERR (8-bit counter).

Ports:
- `CLKCPU` in 1: sole clock. All state changes on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `IDE_ACCESS` in 1: low = decoded IDE cycle. Already qualified with AS20/DS20.
- `AS20` in 1: CPU address strobe, low-active.
- `RW20` in 1: 1 = read.
- `AB` in [4:2]: IDE register select.
- `A12` in 1: 0 = command block (CS0), 1 = control block (CS1).
- `IDEWAIT` in 1: ATA IORDY. 1 = ready.
- `IDE_CS` out [1:0]: low-active {CS1n, CS0n}.
- `IDE_DA` out [2:0]: register address to drive.
- `IDE_IORn` out 1: read strobe.
- `IDE_IOWn` out 1: write strobe.
- `IDE_BUFOEn` out 1: data buffer enable, low-active.
- `IDE_DIR` out 1: 1 = drive → CPU.
- `RD_LATCH` out 1: one-cycle pulse, read data valid for capture.
- `DSACKn` out [1:0]: low-active. 16-bit port termination drives `2'b01`.
- `BERRn` out 1: low-active bus error.

## Operation
- States: IDLE, SETUP, STROBE, TERM, RECOVER. 5-bit down-counter `cnt`, 8-bit `wdog`.
- **IDLE:**
  - Outputs are inactive.
  - On `IDE_ACCESS`=0, latch `AB`, `A12` and `RW20` into DA/CS/dir registers.
  - Assert the selected CS and `BUFOEn`. Set `DIR`=RW20.
  - Load `cnt`=SETUP_CYC-1. Go to SETUP.
- **SETUP:** when `cnt`=0, assert IORn (read) or IOWn (write), load `cnt`=STROBE_CYC-1, clear `wdog`, go to STROBE. Otherwise decrement.
- **STROBE:**
  - Decrement `cnt` to 0, then hold while `IDEWAIT`=0.
  - `wdog` increments every STROBE cycle after `cnt` reaches 0.
  - If `cnt`=0 and `IDEWAIT`=1: release strobe. If read, pulse `RD_LATCH` the same cycle. Assert `DSACKn`=2'b01. Go to TERM.
  - If `wdog`=WAIT_TIMEOUT: release strobe, assert `BERRn`=0, go to TERM.
- **TERM:**
  - Hold DSACK/BERR and CS/DA until `AS20`=1.
  - Then negate DSACK, BERR, CS and BUFOEn, load `cnt`=RECOVER_CYC, go to RECOVER.
- **RECOVER:** decrement to 0, then go to IDLE. A new `IDE_ACCESS` seen here is ignored until IDLE; the CPU holds AS, so no cycle is lost.
- CS/DA/DIR remain stable from SETUP entry through TERM exit; never change while a strobe is low.
- `AS20` rising before TERM (aborted cycle, e.g. reset or exception):
  - Release strobe immediately (next edge).
  - No DSACK.
  - Go to RECOVER with full RECOVER_CYC.
- RESET=1 at any point: next edge forces IDLE. All outputs take reset values regardless of state.

## Timing
- Reset values:
  - `IDE_CS`=2'b11, `IDE_DA`=0
  - `IORn`=`IOWn`=1, `BUFOEn`=1, `DIR`=0, `RD_LATCH`=0
  - `DSACKn`=2'b11, `BERRn`=1
- All outputs are registered; none combinational from inputs.
- Strobe asserts exactly SETUP_CYC+1 edges after `IDE_ACCESS` is sampled low.
- Strobe-low width is STROBE_CYC edges when IORDY is high, STROBE_CYC+k when IORDY is low for k cycles at the end. IORDY is sampled only once `cnt`=0.
- DSACK asserts on the same edge the strobe releases; data hold is provided by CS/BUFOEn persisting in TERM.
- Minimum back-to-back spacing, strobe release to next strobe assert: 1 (TERM) + RECOVER_CYC + 1 (IDLE) + SETUP_CYC + 1 edges.
- `wdog` saturates; BERR asserts exactly WAIT_TIMEOUT cycles after `cnt` reaches 0 with IORDY held low.

## Structure
- Shared package `tf530_pkg`: state enum `ide_state_t` (IDLE=0, SETUP, STROBE, TERM, RECOVER), `DSACK_16`=2'b01, `DSACK_NONE`=2'b11.
- Single module, no sub-modules. Counter and watchdog are inline.
- The upstream address decode stays where it is; this block consumes only its `IDE_ACCESS` output.

## Test plan
- **Reset:** RESET=1 mid-STROBE → next edge: all outputs at reset values, state IDLE.
- **Read:** read AB=3'b111, A12=0, IDEWAIT=1, defaults → CS0n low and IORn low on edge 3 after access; IORn low 8 cycles; `RD_LATCH` and DSACKn=01 on release; CS held until AS20 rises.
- **Write:** write AB=3'b110, A12=1 → CS1n low, DA=6, IOWn low 8 cycles, DIR=0 throughout.
- **IORDY stretch:** IDEWAIT low for 5 cycles spanning strobe end → strobe low 13 cycles, single DSACK.
- **Timeout:** IDEWAIT stuck low → BERRn=0 exactly 255 cycles after `cnt`=0, DSACKn stays 11, RECOVER follows AS20 rise.
- **Abort and back-to-back:** AS20 rises during SETUP → no strobe, no DSACK. Then two consecutive accesses → strobe gap ≥ 1+3+1+2+1 edges.
